// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry / serial arithmetic datapath blocks.
// Holds the serial-unit state encoding used by serial_subtractor.
package rca_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Encoding 2'd3 is never produced; the FSM decodes it as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow-out.
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = x - y - bin, one bit per clock,
// with a start/busy/done handshake and results held until the next operation ends.
module serial_subtractor
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic             accept_c;
    logic             step_c;
    logic             last_c;
    logic             cell_d;
    logic             cell_b;

    fullsubtractor u_cell (
        .a    (x_sr[0]),
        .b    (y_sr[0]),
        .bin  (br),
        .diff (cell_d),
        .bout (cell_b)
    );

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        step_c     = 1'b0;
        last_c     = 1'b0;
        case (state)
            S_RUN: begin
                step_c = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    last_c     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            x_sr  <= '0;
            y_sr  <= '0;
            d_sr  <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_DONE);
            if (accept_c) begin
                x_sr  <= x;
                y_sr  <= y;
                br    <= bin;
                count <= '0;
            end else if (step_c) begin
                x_sr  <= x_sr >> 1;
                y_sr  <= y_sr >> 1;
                br    <= cell_b;
                d_sr  <= {cell_d, d_sr[WIDTH-1:1]};
                count <= last_c ? count : count + CW'(1);
                // On the final bit the shift-register LSBs are the operand MSBs.
                if (last_c) begin
                    diff <= {cell_d, d_sr[WIDTH-1:1]};
                    bout <= cell_b;
                    ovf  <= (x_sr[0] ^ y_sr[0]) & (cell_d ^ x_sr[0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed table, handshake
// corner sequences, exhaustive and random operands against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for diff/borrow, signed range for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ur;
        int sr;
        int sa;
        int sb;
        ur = int'(a) - int'(b) - int'(c);
        bo = (ur < 0);
        d  = W'(ur);
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        sr = sa - sb - int'(c);
        ov = (sr < -8) || (sr > 7);
    endtask

    // Called at #1 after a posedge with the DUT idle; returns results and latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] d, output logic bo, output logic ov,
                          output int lat);
        logic seen;
        start = 1'b1; x = a; y = b; bin = c;
        @(posedge clk); #1;
        start = 1'b0;
        x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
            else check("busy_during_run", 32'(busy), 32'd1);
        end
        check("done_seen", 32'(seen), 32'd1);
        d = diff; bo = bout; ov = ovf;
        @(posedge clk); #1;
        check("done_width", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    vec_t         tbl[$];
    logic [W-1:0] rd;
    logic         rbo;
    logic         rov;
    logic [W-1:0] ed;
    logic         ebo;
    logic         eov;
    int           lat;
    int           t[3];
    int           np;
    int           guard;

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        tbl.push_back('{4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0});
        tbl.push_back('{4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0});
        tbl.push_back('{4'h8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1});
        tbl.push_back('{4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0});
        tbl.push_back('{4'd7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0});
        foreach (tbl[i]) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].bin, rd, rbo, rov, lat);
            check("tbl_diff", 32'(rd),  32'(tbl[i].diff));
            check("tbl_bout", 32'(rbo), 32'(tbl[i].bout));
            check("tbl_ovf",  32'(rov), 32'(tbl[i].ovf));
            check("tbl_latency", 32'(lat), 32'(W));
        end

        // start held high: one result every WIDTH+2 cycles
        start = 1'b1; x = 4'd6; y = 4'd2; bin = 1'b0;
        np = 0; guard = 0;
        while (np < 3 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
            if (done) begin
                t[np] = cyc;
                check("held_diff", 32'(diff), 32'd4);
                np++;
            end
        end
        check("held_pulses", 32'(np), 32'd3);
        if (np == 3) begin
            check("held_spacing0", 32'(t[1] - t[0]), 32'(W + 2));
            check("held_spacing1", 32'(t[2] - t[1]), 32'(W + 2));
        end
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;

        // Inputs change mid-run and start stays high through busy: no effect, no queueing
        start = 1'b1; x = 4'd6; y = 4'd2; bin = 1'b0;
        @(posedge clk); #1;
        x = 4'd9; y = 4'd1; bin = 1'b1;
        guard = 0;
        while (!done && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("midrun_done", 32'(done), 32'd1);
        check("midrun_diff", 32'(diff), 32'd4);
        check("midrun_bout", 32'(bout), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        check("no_queue_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("no_queue_busy2", 32'(busy), 32'd0);

        // Reset in the 2nd RUN cycle discards the operation
        start = 1'b1; x = 4'd9; y = 4'd3; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        check("midrst_ovf",  32'(ovf),  32'd0);
        np = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done || busy) np++;
        end
        check("midrst_quiet", 32'(np), 32'd0);
        run_op(4'd5, 4'd5, 1'b0, rd, rbo, rov, lat);
        check("fresh_diff", 32'(rd),  32'd0);
        check("fresh_bout", 32'(rbo), 32'd0);

        // Exhaustive against the model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(W'(a), W'(b), 1'(c), rd, rbo, rov, lat);
                    model(W'(a), W'(b), 1'(c), ed, ebo, eov);
                    check("exh_diff", 32'(rd),  32'(ed));
                    check("exh_bout", 32'(rbo), 32'(ebo));
                    check("exh_ovf",  32'(rov), 32'(eov));
                    check("exh_latency", 32'(lat), 32'(W));
                end
            end
        end

        // Random operands with random idle gaps
        for (int k = 0; k < 60; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            run_op(ra, rb, rc, rd, rbo, rov, lat);
            model(ra, rb, rc, ed, ebo, eov);
            check("rnd_diff", 32'(rd),  32'(ed));
            check("rnd_bout", 32'(rbo), 32'(ebo));
            check("rnd_ovf",  32'(rov), 32'(eov));
        end

        // Results hold while idle
        repeat (5) @(posedge clk);
        #1;
        check("hold_diff", 32'(diff), 32'(ed));
        check("hold_bout", 32'(bout), 32'(ebo));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
